// File: rtl/rv32im_muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation codes (RV32M funct3)
// and FSM state encoding.
package rv32im_muldiv_pkg;

   localparam int MD_OP_WIDTH = 3;

   typedef enum logic [MD_OP_WIDTH-1:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/rv32im_muldiv_if.sv
// EX-stage request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface rv32im_muldiv_if #(parameter int WIDTH = 32) ();

   logic                                        i_valid;
   logic [rv32im_muldiv_pkg::MD_OP_WIDTH-1:0]   i_md_op;
   logic [WIDTH-1:0]                            i_rs1_data;
   logic [WIDTH-1:0]                            i_rs2_data;
   logic                                        i_flush;
   logic                                        o_ready;
   logic                                        o_busy;
   logic                                        o_valid;
   logic [WIDTH-1:0]                            o_result;

   modport master (
      output i_valid, i_md_op, i_rs1_data, i_rs2_data, i_flush,
      input  o_ready, o_busy, o_valid, o_result
   );

   modport slave (
      input  i_valid, i_md_op, i_rs1_data, i_rs2_data, i_flush,
      output o_ready, o_busy, o_valid, o_result
   );

endinterface

// File: rtl/rv32im_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle. o_done marks the
// final iteration; o_quotient/o_remainder are that iteration's results.
module rv32im_divider #(parameter int WIDTH = 32) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] rem_step, quo_step;

   // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
   assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
   assign fits     = ~trial[WIDTH];
   assign rem_step = fits ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign quo_step = {quo_q[WIDTH-2:0], fits};

   assign o_done      = busy_q && (cnt_q == LAST);
   assign o_quotient  = quo_step;
   assign o_remainder = rem_step;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (i_abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (i_start) begin
         rem_d  = '0;
         quo_d  = i_dividend;
         dvs_d  = i_divisor;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/rv32im_muldiv.sv
// RV32M execute unit: 2-cycle multiply, 33-cycle iterative divide/remainder,
// 1-cycle divide special cases; stalls EX while an operation is in flight.
//
//   state   | meaning
//   IDLE    | ready; accepts a request when i_valid & ~i_flush
//   MUL     | operands registered, product computed and captured
//   DIV     | divider iterating, one quotient bit per cycle
//   DONE    | o_valid pulse, o_result freshly updated
module rv32im_muldiv
   import rv32im_muldiv_pkg::*;
#(parameter int WIDTH = 32) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   rv32im_muldiv_if.slave  md
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               accept, div_signed, rs1_neg, rs2_neg, div_zero, div_ovf;
   logic               a_signed, b_signed, div_start, div_done;
   logic [WIDTH-1:0]   dvd_mag, dvs_mag, div_quo, div_rem, div_res;
   logic [2*WIDTH-1:0] product;

   assign accept     = (state_q == ST_IDLE) && md.i_valid && !md.i_flush;
   assign div_signed = !md.i_md_op[0];
   assign rs1_neg    = div_signed && md.i_rs1_data[WIDTH-1];
   assign rs2_neg    = div_signed && md.i_rs2_data[WIDTH-1];
   assign dvd_mag    = rs1_neg ? -md.i_rs1_data : md.i_rs1_data;
   assign dvs_mag    = rs2_neg ? -md.i_rs2_data : md.i_rs2_data;
   assign div_zero   = (md.i_rs2_data == '0);
   assign div_ovf    = div_signed && (md.i_rs1_data == MIN_NEG) && (md.i_rs2_data == '1);
   assign a_signed   = (md.i_md_op == MD_MULH) || (md.i_md_op == MD_MULHSU);
   assign b_signed   = (md.i_md_op == MD_MULH);

   // Operands are pre-extended to 2*WIDTH so one modulo-2^64 multiply covers all signednesses.
   assign product = mul_a_q * mul_b_q;
   assign div_res = op_q[1] ? (neg_q ? -div_rem : div_rem)
                            : (neg_q ? -div_quo : div_quo);

   assign md.o_ready  = (state_q == ST_IDLE);
   assign md.o_busy   = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign md.o_valid  = (state_q == ST_DONE);
   assign md.o_result = result_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      result_d  = result_q;
      div_start = 1'b0;
      if (md.i_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_d = md_op_e'(md.i_md_op);
                  if (!md.i_md_op[2]) begin
                     mul_a_d = {{WIDTH{a_signed && md.i_rs1_data[WIDTH-1]}}, md.i_rs1_data};
                     mul_b_d = {{WIDTH{b_signed && md.i_rs2_data[WIDTH-1]}}, md.i_rs2_data};
                     state_d = ST_MUL;
                  end else if (div_zero) begin
                     result_d = md.i_md_op[1] ? md.i_rs1_data : '1;
                     state_d  = ST_DONE;
                  end else if (div_ovf) begin
                     result_d = md.i_md_op[1] ? '0 : MIN_NEG;
                     state_d  = ST_DONE;
                  end else begin
                     neg_d     = md.i_md_op[1] ? rs1_neg : (rs1_neg ^ rs2_neg);
                     div_start = 1'b1;
                     state_d   = ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               result_d = (op_q == MD_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
               state_d  = ST_DONE;
            end
            ST_DIV: begin
               if (div_done) begin
                  result_d = div_res;
                  state_d  = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_MUL;
         neg_q    <= 1'b0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         result_q <= result_d;
      end
   end

   rv32im_divider #(.WIDTH(WIDTH)) u_divider (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (div_start),
      .i_abort     (md.i_flush),
      .i_dividend  (dvd_mag),
      .i_divisor   (dvs_mag),
      .o_done      (div_done),
      .o_quotient  (div_quo),
      .o_remainder (div_rem)
   );

endmodule

// File: doc/rv32im_muldiv.md
Name: rv32im_muldiv

Overview:
- M-extension execute unit. Sits beside rv32i_alu in the EX stage and takes the same forwarded rs1/rs2 operands.
- Its result is muxed with the ALU result into the EX/MEM register.
- Multi-cycle: multiply takes a fixed 2 cycles; divide/remainder uses an iterative radix-2 restoring divider (33 cycles).
- Asserts a stall request to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  EX holds an M-extension instruction; request to start.
- i_md_op  in  3  operation; encoding equals RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- i_rs1_data  in  WIDTH  dividend / multiplicand (post-forwarding).
- i_rs2_data  in  WIDTH  divisor / multiplier (post-forwarding).
- i_flush  in  1  kill the in-flight operation (branch mispredict/trap).
- o_ready  out  1  unit idle, can accept.
- o_busy  out  1  stall request to hazard unit.
- o_valid  out  1  one-cycle pulse; o_result valid.
- o_result  out  WIDTH  result.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, o_valid=0, o_result=0, iteration counter=0, internal registers=0, o_ready=1, o_busy=0.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: cycle N with state==IDLE, i_valid=1, i_flush=0. Operands and op are registered.
  - MUL ops → MUL.
  - DIV/REM ops → DIV, counter=0.
  - Special-case divide (see below) → DONE directly.
- MUL state (cycle N+1): full 2*WIDTH signed/unsigned product registered → DONE. Operand sign handling:
  - MULH: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/MUL: both unsigned.
  - MUL returns product[31:0]; the MULH* ops return product[63:32].
- DIV state:
  - Operands converted to magnitudes at accept.
  - One quotient bit per cycle for 32 cycles (N+1..N+32); counter increments each cycle.
  - At counter==31 → DONE.
  - Quotient sign = sign(rs1) XOR sign(rs2) for DIV only. Remainder sign = sign(rs1) for REM only. Unsigned ops do no sign fixup.
- Special cases, resolved at accept, result at N+1:
  - Divisor 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM only): DIV = 0x80000000, REM = 0.
- DONE: o_valid=1 for exactly one cycle, o_result updated; next state IDLE.
  - Latency: MUL* = 2 cycles (valid at N+2); DIV* = 33 cycles (valid at N+33); special cases = 1 cycle (valid at N+1).
- o_result holds its last value until the next DONE.
- o_ready = (state==IDLE).
- o_busy = (state==IDLE & i_valid & ~i_flush) | state==MUL | state==DIV. Combinational.
  - Consequence: EX stalls from the accept cycle and is released in the DONE cycle, when EX/MEM captures o_result.
- i_valid while state≠IDLE: ignored; no queuing.
- i_flush (synchronous, highest priority after reset):
  - Any state → IDLE next cycle; no o_valid produced; counter cleared.
  - Flush in the same cycle as i_valid: not accepted.
  - Flush during DONE: that cycle's o_valid still asserts (result already committed by the pipeline).
- Async reset mid-operation: outputs go to reset values immediately; no result emitted after release.

Decomposition:
- Shared header rv32i_decoder_header.vh gains MD_OP_WIDTH, MD_MUL..MD_REMU opcode macros and the muldiv FSM state encodings.
- One sub-module, rv32im_divider:
  - Unsigned restoring-divider core with start/done handshake.
  - Holds the remainder/quotient shift registers and counter.
  - Sign fixup and special cases remain in rv32im_muldiv.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD → o_result=0xFFFFFFEB, o_valid at N+2; o_busy=1 in N,N+1 and 0 in N+2.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
3. DIV 0xFFFFFFEC(−20)/3 → 0xFFFFFFFA, o_valid at N+33; REM same operands → 0xFFFFFFFE; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIVU 100/0 → 0xFFFFFFFF at N+1; REM 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. All at N+1.
5. DIV started at N, i_flush at N+10 → no o_valid ever, o_ready=1 at N+11; MUL 6×7 accepted at N+11 → 42 at N+13.
6. i_rst_n low at N+5 of a DIV → o_valid=0, o_result=0, o_ready=1 immediately. After release, i_valid held high through the run while busy → exactly one accept and one o_valid pulse.
